mod_range_counter: RTL

MOD_RANGE_COUNTER -- requirements
Module: mod_range_counter

---
 rtl/mod_range_counter_pkg.sv | 26 ++
 rtl/mod_range_counter_bin2bcd.sv | 31 +++
 rtl/mod_range_counter.sv | 113 +++++++++++
 3 files changed

// File: rtl/mod_range_counter_pkg.sv
// Shared constants and step decoding for the bounded up/down counter.
// The optional BCD view (MOD_RANGE_COUNTER_BCD_EN) uses BCD_DIGIT_W from here.
package mod_range_counter_pkg;

  localparam int DEFAULT_W   = 8;
  localparam int DEFAULT_MIN = 1;
  localparam int DEFAULT_MAX = 12;
  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 3;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DOWN,
    STEP_CONFLICT
  } step_op_e;

  function automatic step_op_e decode_step(input logic en, input logic up, input logic down);
    if (!en)            return STEP_HOLD;
    if (up && down)     return STEP_CONFLICT;
    if (up)             return STEP_UP;
    if (down)           return STEP_DOWN;
    return STEP_HOLD;
  endfunction

endpackage

// File: rtl/mod_range_counter_bin2bcd.sv
// Combinational binary to three-digit BCD converter (shift-and-add-3).
// Values above 999 keep only the low three digits.
module mod_range_counter_bin2bcd
  import mod_range_counter_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0]                      i_bin,
  output logic [BCD_DIGITS*BCD_DIGIT_W-1:0] o_bcd
);

  localparam int BCD_W = BCD_DIGITS * BCD_DIGIT_W;

  logic [BCD_W+W-1:0] w_shift;

  always_comb begin
    w_shift = '0;
    w_shift[W-1:0] = i_bin;
    for (int i = 0; i < W; i++) begin
      for (int d = 0; d < BCD_DIGITS; d++) begin
        if (w_shift[W + d*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5)
          w_shift[W + d*BCD_DIGIT_W +: BCD_DIGIT_W] =
            w_shift[W + d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
      end
      w_shift = w_shift << 1;
    end
  end

  assign o_bcd = w_shift[W +: BCD_W];

endmodule

// File: rtl/mod_range_counter.sv
// Up/down counter confined to [MIN,MAX] with wrap/saturate, load and event pulses.
// Define MOD_RANGE_COUNTER_BCD_EN to add the combinational 'bcd' output.
module mod_range_counter
  import mod_range_counter_pkg::*;
#(
  parameter int W   = DEFAULT_W,
  parameter int MIN = DEFAULT_MIN,
  parameter int MAX = DEFAULT_MAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         down,
  input  logic         wrap,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] out,
  output logic         carry,
  output logic         borrow,
`ifdef MOD_RANGE_COUNTER_BCD_EN
  output logic         err,
  output logic [BCD_DIGITS*BCD_DIGIT_W-1:0] bcd
`else
  output logic         err
`endif
);

  if (!(MIN < MAX) || (longint'(MAX) >= (longint'(1) << W))) begin : g_bad_params
    $error("mod_range_counter: need MIN < MAX and MAX < 2**W");
  end

  localparam logic [W-1:0] MIN_V = W'(MIN);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_out;
  logic         r_carry;
  logic         r_borrow;
  logic         r_err;

  logic [W-1:0] w_next;
  logic         w_carry;
  logic         w_borrow;
  logic         w_err;
  step_op_e     w_op;

  assign w_op = decode_step(en, up, down);

  // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    w_next   = r_out;
    w_carry  = 1'b0;
    w_borrow = 1'b0;
    w_err    = 1'b0;
    if (load) begin
      if (load_val >= MIN_V && load_val <= MAX_V) begin
        w_next = load_val;
      end else begin
        w_next = MIN_V;
        w_err  = 1'b1;
      end
    end else begin
      unique case (w_op)
        STEP_UP: begin
          if (r_out < MAX_V) begin
            w_next = r_out + 1'b1;
          end else if (wrap) begin
            w_next  = MIN_V;
            w_carry = 1'b1;
          end
        end
        STEP_DOWN: begin
          if (r_out > MIN_V) begin
            w_next = r_out - 1'b1;
          end else if (wrap) begin
            w_next   = MAX_V;
            w_borrow = 1'b1;
          end
        end
        STEP_CONFLICT: w_err = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out    <= MIN_V;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_out    <= w_next;
      r_carry  <= w_carry;
      r_borrow <= w_borrow;
      r_err    <= w_err;
    end
  end

  assign out    = r_out;
  assign carry  = r_carry;
  assign borrow = r_borrow;
  assign err    = r_err;

`ifdef MOD_RANGE_COUNTER_BCD_EN
  mod_range_counter_bin2bcd #(.W(W)) u_bin2bcd (
    .i_bin (r_out),
    .o_bcd (bcd)
  );
`endif

endmodule
